// File: rtl/imm_ext_unit_if.sv
// imm_ext_unit_if: valid/ready bundle between decode, the immediate generator and execute.
interface imm_ext_unit_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [24:0]     inst;
   logic [2:0]      imm_sel;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
   logic            out_illegal;
   logic [7:0]      err_cnt;
   modport master (output in_valid, inst, imm_sel, out_ready,
                   input  in_ready, out_valid, imm, out_illegal, err_cnt);
   modport slave  (input  in_valid, inst, imm_sel, out_ready,
                   output in_ready, out_valid, imm, out_illegal, err_cnt);
endinterface

// File: rtl/imm_ext_unit.sv
// imm_ext_unit: registered RISC-V immediate generator behind a 2-entry valid/ready buffer.
// Define IMM_ERRCNT_EN to build the saturating illegal-select counter on err_cnt.
module imm_ext_unit #(parameter int XLEN = 32) (
   input logic           clk,
   input logic           rst_n,
   imm_ext_unit_if.slave bus
);
   logic            s;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_d;
   logic            ill_d;
   logic [XLEN:0]   mem_q [2];
   logic            head_q;
   logic [1:0]      cnt_q;
   logic            tail;
   logic            push;
   logic            pop;
   assign s = bus.inst[24];
   assign ill_d = bus.imm_sel[2] & bus.imm_sel[1];
   // Every format is built as a 32-bit value and then sign-extended; Z and illegal keep bit 31 clear.
   assign imm32 = bus.imm_sel == 3'd0 ? {{20{s}}, bus.inst[24:13]} :
                  bus.imm_sel == 3'd1 ? {{20{s}}, bus.inst[0], bus.inst[23:18], bus.inst[4:1], 1'b0} :
                  bus.imm_sel == 3'd2 ? {{20{s}}, bus.inst[24:18], bus.inst[4:0]} :
                  bus.imm_sel == 3'd3 ? {{12{s}}, bus.inst[12:5], bus.inst[13], bus.inst[23:14], 1'b0} :
                  bus.imm_sel == 3'd4 ? {bus.inst[24:5], 12'b0} :
                  bus.imm_sel == 3'd5 ? {27'b0, bus.inst[12:8]} : 32'd0;
   assign imm_d = XLEN'($signed(imm32));
   assign bus.in_ready  = cnt_q != 2'd2;
   assign bus.out_valid = cnt_q != 2'd0;
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;
   assign tail = head_q ^ cnt_q[0];
   assign {bus.out_illegal, bus.imm} = bus.out_valid ? mem_q[head_q] : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         head_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         if (push) mem_q[tail] <= {ill_d, imm_d};
         if (pop) head_q <= ~head_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end
`ifdef IMM_ERRCNT_EN
   logic [7:0] err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 8'd0;
      else if (push && ill_d && err_q != 8'hFF) err_q <= err_q + 8'd1;
   end
   assign bus.err_cnt = err_q;
`else
   assign bus.err_cnt = 8'd0;
`endif
endmodule
